// File: rtl/checkpoint_queue.sv
// Branch-checkpoint queue for the rename stage.
// Each entry holds a rename snapshot (free list, RMT, BBL) and an active-list tag.
// Allocation happens at front and retirement at back. A mispredict recall rewinds
// front to the recalled entry and returns that entry's snapshot one cycle later.

module checkpoint_queue #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 640,
  parameter int TAG_W     = 5,
  parameter int ALLOC_W   = 2,
  parameter int RES_W     = 2,
  parameter int RET_W     = 2,
  localparam int ID_W     = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ALLOC_W-1:0]                  alloc_req_i,
  input  logic [ALLOC_W-1:0][PAYLOAD_W-1:0]   alloc_payload_i,
  input  logic [ALLOC_W-1:0][TAG_W-1:0]       alloc_tag_i,
  output logic                                alloc_ready_o,
  output logic [ALLOC_W-1:0][ID_W-1:0]        alloc_id_o,
  input  logic [RES_W-1:0]                    validate_i,
  input  logic [RES_W-1:0][ID_W-1:0]          validate_id_i,
  input  logic                                recall_i,
  input  logic [ID_W-1:0]                     recall_id_i,
  output logic                                recall_data_valid_o,
  output logic [PAYLOAD_W-1:0]                recall_data_o,
  output logic [TAG_W-1:0]                    recall_tag_o,
  output logic [TAG_W-1:0]                    oldest_tag_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic [ID_W:0]                       count_o
);

  localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(DEPTH);
  localparam logic [ID_W:0] ALLOC_C = (ID_W+1)'(ALLOC_W);
  localparam logic [ID_W:0] ONE_C   = (ID_W+1)'(1);

  logic [ID_W-1:0]      front_q, front_d;
  logic [ID_W-1:0]      back_q, back_d;
  logic [ID_W:0]        count_q, count_d;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [TAG_W-1:0]     tag_q [DEPTH];

  logic                 rdv_q;
  logic [PAYLOAD_W-1:0] rdata_q;
  logic [TAG_W-1:0]     rtag_q;

  logic [ID_W:0]        n_req;
  logic [ID_W:0]        n_alloc;
  logic [ID_W:0]        n_ret;
  logic                 do_alloc;
  logic [ID_W-1:0]      recall_dist;
  logic                 recall_live;
  logic [ID_W:0]        ret_limit;
  logic                 ret_run;

  // Distance from back to the recalled id; entries below it survive a recall.
  assign recall_dist = recall_id_i - back_q;
  assign recall_live = ({1'b0, recall_dist} < count_q);

  // A recall blocks allocation; otherwise room for a full set of lanes is needed.
  assign alloc_ready_o = !recall_i && ((DEPTH_C - count_q) >= ALLOC_C);

  assign empty_o             = (count_q == '0);
  assign full_o              = (count_q == DEPTH_C);
  assign count_o             = count_q;
  assign oldest_tag_o        = tag_q[back_q];
  assign recall_data_valid_o = rdv_q;
  assign recall_data_o       = rdata_q;
  assign recall_tag_o        = rtag_q;

  // Pack requesting lanes onto consecutive ids starting at front.
  always_comb begin
    n_req      = '0;
    alloc_id_o = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_id_o[k] = front_q + n_req[ID_W-1:0];
      if (alloc_req_i[k]) begin
        n_req = n_req + ONE_C;
      end else begin
        n_req = n_req;
      end
    end
    do_alloc = alloc_ready_o && (|alloc_req_i);
    if (do_alloc) begin
      n_alloc = n_req;
    end else begin
      n_alloc = '0;
    end
  end

  // Retire the in-order run of validated entries at back, stopping at the recall point.
  always_comb begin
    n_ret   = '0;
    ret_run = 1'b1;
    if (recall_i) begin
      ret_limit = {1'b0, recall_dist};
    end else begin
      ret_limit = count_q;
    end
    for (int j = 0; j < RET_W; j++) begin
      if (ret_run && vld_q[back_q + ID_W'(j)] && ((ID_W+1)'(j) < ret_limit)) begin
        n_ret = n_ret + ONE_C;
      end else begin
        ret_run = 1'b0;
      end
    end
  end

  // Next validated bits: set live validates, then clear retired and newly allocated entries.
  always_comb begin
    vld_d = vld_q;
    for (int p = 0; p < RES_W; p++) begin
      if (validate_i[p] && ({1'b0, validate_id_i[p] - back_q} < count_q) &&
          (!recall_i || ((validate_id_i[p] - back_q) < recall_dist))) begin
        vld_d[validate_id_i[p]] = 1'b1;
      end else begin
        vld_d = vld_d;
      end
    end
    for (int j = 0; j < RET_W; j++) begin
      if ((ID_W+1)'(j) < n_ret) begin
        vld_d[back_q + ID_W'(j)] = 1'b0;
      end else begin
        vld_d = vld_d;
      end
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      if (do_alloc && alloc_req_i[k]) begin
        vld_d[alloc_id_o[k]] = 1'b0;
      end else begin
        vld_d = vld_d;
      end
    end
  end

  // Next pointers and occupancy; a recall rewinds front and recomputes count.
  always_comb begin
    back_d = back_q + n_ret[ID_W-1:0];
    if (recall_i) begin
      front_d = recall_id_i;
      count_d = {1'b0, recall_dist} - n_ret;
    end else begin
      front_d = front_q + n_alloc[ID_W-1:0];
      count_d = count_q + n_alloc - n_ret;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_q <= '0;
      back_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      front_q <= front_d;
      back_q  <= back_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Snapshot storage; contents only matter once an entry has been allocated.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ALLOC_W; k++) begin
      if (do_alloc && alloc_req_i[k]) begin
        payload_q[alloc_id_o[k]] <= alloc_payload_i[k];
      end
    end
  end

  // Tag storage, cleared on reset so oldest_tag reads zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int k = 0; k < ALLOC_W; k++) begin
        if (do_alloc && alloc_req_i[k]) begin
          tag_q[alloc_id_o[k]] <= alloc_tag_i[k];
        end
      end
    end
  end

  // Capture the recalled snapshot for presentation on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      rtag_q  <= '0;
    end else if (recall_i) begin
      rdv_q   <= 1'b1;
      rdata_q <= payload_q[recall_id_i];
      rtag_q  <= tag_q[recall_id_i];
    end else begin
      rdv_q   <= 1'b0;
    end
  end

  checkpoint_queue_checker u_checker (
    .clk           (clk),
    .reset         (reset),
    .recall_i      (recall_i),
    .recall_live_i (recall_live)
  );

endmodule

// Protocol checks for checkpoint_queue.
module checkpoint_queue_checker (
  input logic clk,
  input logic reset,
  input logic recall_i,
  input logic recall_live_i
);

  // A recall must name a checkpoint that is currently live.
  always_ff @(posedge clk) begin
    if (!reset && recall_i) begin
      assert (recall_live_i) else $error("checkpoint_queue: recall of non-live checkpoint");
    end
  end

endmodule
